// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 keystream generator.
package rc4_pkg;

    localparam int unsigned SBOX_SIZE      = 256;
    localparam int unsigned RC4_KSA_CYCLES = 257;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA,
        ST_DROP,
        ST_PRGA
    } rc4_state_t;

endpackage

// File: rtl/rc4_stream_gen_if.sv
// Key-load / keystream handshake bundle between the controller (master) and the generator (slave).
interface rc4_stream_gen_if
    import rc4_pkg::*;
#(
    parameter int unsigned KEY_MAX_BYTES = 16
);
    logic                       start;
    logic                       stop;
    logic [KEY_MAX_BYTES*8-1:0] key;
    byte_t                      key_length;
    logic                       busy;
    logic                       key_err;
    logic                       ks_valid;
    logic                       ks_ready;
    byte_t                      ks_data;

    modport master (
        output start, stop, key, key_length, ks_ready,
        input  busy, key_err, ks_valid, ks_data
    );

    modport slave (
        input  start, stop, key, key_length, ks_ready,
        output busy, key_err, ks_valid, ks_data
    );
endinterface

// File: rtl/rc4_sbox.sv
// 256x8 RC4 state array: two swap read ports, one output-index read port, dual-write swap, identity init.
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic  clk,
    input  logic  init,
    input  logic  swap,
    input  byte_t rd_a_idx,
    input  byte_t rd_b_idx,
    input  byte_t out_idx,
    output byte_t rd_a_data_c,
    output byte_t rd_b_data_c,
    output byte_t out_data_c,
    input  byte_t wr_a_idx,
    input  byte_t wr_a_data,
    input  byte_t wr_b_idx,
    input  byte_t wr_b_data
);

    byte_t s [SBOX_SIZE];

    assign rd_a_data_c = s[rd_a_idx];
    assign rd_b_data_c = s[rd_b_idx];
    assign out_data_c  = s[out_idx];

    // When both swap indices coincide both writes carry the same value, so order is irrelevant.
    always_ff @(posedge clk) begin
        if (init) begin
            for (int unsigned k = 0; k < SBOX_SIZE; k++) begin
                s[k] <= byte_t'(k);
            end
        end else if (swap) begin
            s[wr_a_idx] <= wr_a_data;
            s[wr_b_idx] <= wr_b_data;
        end
    end

endmodule

// File: rtl/rc4_stream_gen.sv
// RC4 keystream generator: key latch, KSA, optional RC4-drop[N] (RC4_DROP_EN), valid/ready byte stream.
module rc4_stream_gen
    import rc4_pkg::*;
#(
    parameter int unsigned KEY_MAX_BYTES = 16,
    parameter int unsigned DROP_N        = 768
) (
    input logic             clk,
    input logic             rst,
    rc4_stream_gen_if.slave bus
);

    localparam int unsigned KEY_W = KEY_MAX_BYTES * 8;

    rc4_state_t       state, state_n;
    byte_t            i, i_n, j, j_n, kidx, kidx_n, len_q, len_n;
    logic [KEY_W-1:0] key_q, key_n;
    logic             busy_q, err_q, err_n, valid_q, valid_n;
    byte_t            data_q, data_n;

    logic  sb_init, sb_swap, start_legal;
    byte_t rd_a_idx, rd_b_idx, out_idx, sa, sb, sout;
    byte_t key_byte, i_prga, j_ksa, j_prga, prga_byte;

`ifdef RC4_DROP_EN
    localparam int unsigned DROP_W = (DROP_N > 1) ? $clog2(DROP_N) : 1;
    logic [DROP_W-1:0] drop_cnt, drop_cnt_n;
`else
    // DROP_N has no effect without the drop stage.
    logic unused_drop_n;
    assign unused_drop_n = ^DROP_N;
`endif

    assign start_legal = (bus.key_length != 8'd0) && (32'(bus.key_length) <= KEY_MAX_BYTES);

    // Shared swap datapath: KSA reads S[i], PRGA/DROP read S[i+1].
    assign key_byte  = byte_t'(key_q >> {kidx, 3'b000});
    assign i_prga    = i + 8'd1;
    assign rd_a_idx  = (state == ST_KSA) ? i : i_prga;
    assign j_ksa     = j + sa + key_byte;
    assign j_prga    = j + sa;
    assign rd_b_idx  = (state == ST_KSA) ? j_ksa : j_prga;
    assign out_idx   = sa + sb;
    assign prga_byte = (out_idx == i_prga) ? sb :
                       (out_idx == j_prga) ? sa : sout;

    rc4_sbox u_sbox (
        .clk         (clk),
        .init        (sb_init),
        .swap        (sb_swap),
        .rd_a_idx    (rd_a_idx),
        .rd_b_idx    (rd_b_idx),
        .out_idx     (out_idx),
        .rd_a_data_c (sa),
        .rd_b_data_c (sb),
        .out_data_c  (sout),
        .wr_a_idx    (rd_a_idx),
        .wr_a_data   (sb),
        .wr_b_idx    (rd_b_idx),
        .wr_b_data   (sa)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            i       <= '0;
            j       <= '0;
            kidx    <= '0;
            len_q   <= '0;
            key_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
`ifdef RC4_DROP_EN
            drop_cnt <= '0;
`endif
        end else begin
            state   <= state_n;
            i       <= i_n;
            j       <= j_n;
            kidx    <= kidx_n;
            len_q   <= len_n;
            key_q   <= key_n;
            busy_q  <= (state_n == ST_INIT) || (state_n == ST_KSA) || (state_n == ST_DROP);
            err_q   <= err_n;
            valid_q <= valid_n;
            data_q  <= data_n;
`ifdef RC4_DROP_EN
            drop_cnt <= drop_cnt_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        i_n     = i;
        j_n     = j;
        kidx_n  = kidx;
        len_n   = len_q;
        key_n   = key_q;
        err_n   = err_q;
        valid_n = valid_q;
        data_n  = data_q;
        sb_init = 1'b0;
        sb_swap = 1'b0;
`ifdef RC4_DROP_EN
        drop_cnt_n = drop_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (start_legal) begin
                        key_n   = bus.key;
                        len_n   = bus.key_length;
                        err_n   = 1'b0;
                        state_n = ST_INIT;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ST_INIT: begin
                sb_init = 1'b1;
                i_n     = '0;
                j_n     = '0;
                kidx_n  = '0;
                state_n = ST_KSA;
            end
            ST_KSA: begin
                sb_swap = 1'b1;
                i_n     = i + 8'd1;
                j_n     = j_ksa;
                kidx_n  = (kidx == len_q - 8'd1) ? 8'd0 : kidx + 8'd1;
                if (i == 8'd255) begin
                    j_n = '0;
`ifdef RC4_DROP_EN
                    drop_cnt_n = '0;
                    state_n    = (DROP_N == 0) ? ST_PRGA : ST_DROP;
`else
                    state_n = ST_PRGA;
`endif
                end
            end
`ifdef RC4_DROP_EN
            ST_DROP: begin
                sb_swap    = 1'b1;
                i_n        = i_prga;
                j_n        = j_prga;
                drop_cnt_n = drop_cnt + DROP_W'(1);
                if (drop_cnt == DROP_W'(DROP_N - 1)) begin
                    state_n = ST_PRGA;
                end
            end
`endif
            ST_PRGA: begin
                if (bus.start && start_legal) begin
                    key_n   = bus.key;
                    len_n   = bus.key_length;
                    err_n   = 1'b0;
                    valid_n = 1'b0;
                    data_n  = '0;
                    state_n = ST_INIT;
                end else if (bus.stop && !bus.start) begin
                    valid_n = 1'b0;
                    data_n  = '0;
                    state_n = ST_IDLE;
                end else begin
                    if (bus.start) begin
                        err_n = 1'b1;
                    end
                    if (!valid_q || bus.ks_ready) begin
                        sb_swap = 1'b1;
                        i_n     = i_prga;
                        j_n     = j_prga;
                        data_n  = prga_byte;
                        valid_n = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.key_err  = err_q;
    assign bus.ks_valid = valid_q;
    assign bus.ks_data  = data_q;

endmodule
